fifo_word_byte_serializer: RTL
==============================

Name: fifo_word_byte_serializer

Overview:
- Downstream consumer of the 32-bit FIFO queue.
- Pops 32-bit words from the FIFO read port and emits them as a stream of 8-bit bytes on a valid/ready handshake, for byte-wide sinks such as UART TX or an SPI shifter.
- Owns the FIFO read-enable; the FIFO is never read unless a full word can be captured.

Parameters:
- LSB_FIRST, 1, 1 = byte 0 is bits [7:0]; 0 = byte 0 is bits [31:24].
- COUNT_WIDTH, 16, width of the completed-word counter.

Ports:
- Clk_In  input  1  clock; all state updates on rising edge.
- Reset_In  input  1  reset, asynchronous, active-high.
- Enable_In  input  1  permits new FIFO reads; does not abort a word in progress.
- Fifo_Data_In  input  32  FIFO read data; may be high-Z except in the capture window.
- Fifo_Empty_In  input  1  FIFO empty flag.
- Fifo_Read_Enable_Out  output  1  FIFO read request, registered.
- Byte_Out  output  8  current byte.
- Byte_Valid_Out  output  1  Byte_Out holds a valid byte.
- Byte_Ready_In  input  1  sink accepts the byte on a rising edge where Valid=Ready=1.
- Busy_Out  output  1  high in any state other than IDLE.
- Word_Count_Out  output  COUNT_WIDTH  number of words fully transmitted; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset values (asynchronous; all outputs registered):
  - state=IDLE; Fifo_Read_Enable_Out=0, Byte_Valid_Out=0, Byte_Out=8'h00, Busy_Out=0, Word_Count_Out=0.
  - Shift register and byte index cleared.
  - Reset mid-word discards the captured word with no partial count.
- FIFO timing contract:
  - The FIFO updates on the falling edge.
  - Read data is valid only at the first rising edge after the rising edge that raised Fifo_Read_Enable_Out.
  - Fifo_Data_In must be sampled exactly at that edge and is ignored at all other times.
- States:
  - IDLE:
    - On a rising edge with Enable_In=1 and Fifo_Empty_In=0: go to REQ and set Fifo_Read_Enable_Out=1.
    - Otherwise stay in IDLE.
  - REQ (exactly 1 cycle, Read_Enable=1):
    - At the next rising edge, capture Fifo_Data_In into a 32-bit shift register and clear Fifo_Read_Enable_Out.
    - Set byte index=0 and go to SEND with Byte_Valid_Out=1 and Byte_Out=byte 0 (per LSB_FIRST).
  - SEND:
    - Byte_Out and Byte_Valid_Out hold stable while Byte_Ready_In=0. No timeout.
    - On accept with index<3: index+1; the next byte appears on the following cycle with Valid still 1 (no bubble).
    - On accept with index==3: Word_Count_Out+1.
      - If Enable_In=1 and Fifo_Empty_In=0: go to REQ with Valid=0.
      - Otherwise go to IDLE with Valid=0.
- Latency and throughput:
  - Not-empty sampled at edge e0 → Read_Enable high during e0..e1 → first byte valid from e1.
  - Maximum throughput is 4 bytes per 5 cycles.
- Fifo_Read_Enable_Out:
  - Never asserted in SEND.
  - Never asserted for 2 consecutive cycles.
  - Never asserted when Fifo_Empty_In was 1 at the deciding edge.
- Enable_In deasserted during REQ or SEND: the current word completes normally; no further read is issued.
- Byte_Ready_In is ignored when Byte_Valid_Out=0.
- Word_Count_Out wrap: from all-ones the next increment gives 0.

Test Plan:
- Reset then FIFO holding one word 32'hA1B2C3D4, LSB_FIRST=1, Ready tied 1 → one Read_Enable pulse; bytes D4,C3,B2,A1 on 4 consecutive cycles; Word_Count=1; returns to IDLE with Busy=0.
- Same word with LSB_FIRST=0 → bytes A1,B2,C3,D4.
- Ready held 0 for 3 cycles on byte 1 of 32'h11223344 → Byte_Out stays 8'h33 with Valid=1 throughout; no extra Read_Enable; stream then completes as 44,33,22,11.
- FIFO holding 3 words, Ready=1 → 12 bytes in order with exactly one REQ cycle between words (Valid low for 1 cycle each); Word_Count=3; no read attempted once Empty=1.
- Enable_In=0 with non-empty FIFO → no Read_Enable for 10 cycles; Enable_In dropped in the middle of SEND → current word finishes and no new REQ follows.
- Reset_In asserted asynchronously during SEND byte 2 → all outputs return to reset values immediately; after release with an empty FIFO, Busy stays 0 and Word_Count=0.

Source files
------------

// File: rtl/fifo_word_byte_serializer.sv
// Pops 32-bit words from a falling-edge FIFO and streams them out as bytes over valid/ready.
// The read enable is issued only when a whole word can be captured and shifted out.
module fifo_word_byte_serializer #(
    parameter bit LSB_FIRST   = 1'b1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clk_In,
    input  logic                   Reset_In,
    input  logic                   Enable_In,
    input  logic [31:0]            Fifo_Data_In,
    input  logic                   Fifo_Empty_In,
    output logic                   Fifo_Read_Enable_Out,
    output logic [7:0]             Byte_Out,
    output logic                   Byte_Valid_Out,
    input  logic                   Byte_Ready_In,
    output logic                   Busy_Out,
    output logic [COUNT_WIDTH-1:0] Word_Count_Out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [31:0]            r_shift;
    logic [31:0]            w_shift_next;
    logic [1:0]             r_index;
    logic [1:0]             w_index_next;
    logic [7:0]             r_byte;
    logic [7:0]             w_byte_next;
    logic                   r_valid;
    logic                   w_valid_next;
    logic                   r_rd_en;
    logic                   w_rd_en_next;
    logic                   r_busy;
    logic                   w_busy_next;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_next;

    logic w_start;
    logic w_accept;
    logic w_last_byte;

    assign w_start     = Enable_In && !Fifo_Empty_In;
    assign w_accept    = (r_state == ST_SEND) && r_valid && Byte_Ready_In;
    assign w_last_byte = (r_index == 2'd3);

    function automatic logic [7:0] head_byte(input logic [31:0] word);
        return LSB_FIRST ? word[7:0] : word[31:24];
    endfunction

    function automatic logic [31:0] drop_byte(input logic [31:0] word);
        return LSB_FIRST ? {8'h00, word[31:8]} : {word[23:0], 8'h00};
    endfunction

    // NOTE: asynchronous reset belongs in the sensitivity list; state uses <= so all
    // registers update together from values computed in the same cycle.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_index <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_index <= w_index_next;
            r_byte  <= w_byte_next;
            r_valid <= w_valid_next;
            r_rd_en <= w_rd_en_next;
            r_busy  <= w_busy_next;
            r_count <= w_count_next;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_REQ;
            ST_REQ:  w_state_next = ST_SEND;
            ST_SEND: begin
                if (w_accept && w_last_byte) begin
                    w_state_next = w_start ? ST_REQ : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Computes next values for the registered outputs; the read request is high exactly
    // for the one cycle spent in REQ, which is when the FIFO presents its word.
    always_comb begin
        w_shift_next = r_shift;
        w_index_next = r_index;
        w_byte_next  = r_byte;
        w_valid_next = r_valid;
        w_count_next = r_count;
        w_rd_en_next = (w_state_next == ST_REQ);
        w_busy_next  = (w_state_next != ST_IDLE);
        case (r_state)
            ST_REQ: begin
                w_shift_next = drop_byte(Fifo_Data_In);
                w_byte_next  = head_byte(Fifo_Data_In);
                w_index_next = 2'd0;
                w_valid_next = 1'b1;
            end
            ST_SEND: begin
                if (w_accept) begin
                    if (w_last_byte) begin
                        w_valid_next = 1'b0;
                        w_count_next = r_count + COUNT_WIDTH'(1);
                    end else begin
                        w_byte_next  = head_byte(r_shift);
                        w_shift_next = drop_byte(r_shift);
                        w_index_next = r_index + 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign Fifo_Read_Enable_Out = r_rd_en;
    assign Byte_Out             = r_byte;
    assign Byte_Valid_Out       = r_valid;
    assign Busy_Out             = r_busy;
    assign Word_Count_Out       = r_count;

endmodule
